// File: rtl/fc_inneuron_loader.sv
// fc_inneuron_loader
// Write side of the FC input-neuron dual-port RAM. Neurons arrive as a
// valid/ready stream and are packed in pairs: port A holds neuron 2k and
// port B holds neuron 2k+1, both at address k. An odd neuron count ends
// with a zero-padded flush write. After the last write, fc_enable is raised
// and held until the next start.
//
// Ports
//   clock                   rising-edge clock
//   reset                   asynchronous active-low reset
//   start                   single-cycle pulse, begins a load (IDLE or DONE)
//   in_valid/in_data        input neuron stream
//   in_ready                high only while loading
//   in_neuron_wren_a/b      registered paired write enables
//   in_neuron_address_a/b   write address (both ports identical)
//   in_neuron_data_a/b      even / odd neuron write data
//   busy                    high in LOAD and FLUSH
//   load_done               pulse coincident with the last write
//   fc_enable               level start to the FC layer controller
module fc_inneuron_loader #(
  parameter int INNEURON               = 500,
  parameter int DATA_WIDTH_FC          = 16,
  parameter int FC_INNEURON_ADDR_WIDTH = 8,
  parameter int FC_COUNT_IN_BITWIDTH   = 9
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH_FC-1:0]          in_data,
  output logic                              in_ready,
  output logic                              in_neuron_wren_a,
  output logic                              in_neuron_wren_b,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_address_a,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_address_b,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_a,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_b,
  output logic                              busy,
  output logic                              load_done,
  output logic                              fc_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [FC_COUNT_IN_BITWIDTH-1:0]   LAST_CNT = FC_COUNT_IN_BITWIDTH'(INNEURON - 1);
  localparam logic [FC_COUNT_IN_BITWIDTH-1:0]   CNT_ONE  = FC_COUNT_IN_BITWIDTH'(1);
  localparam logic [FC_INNEURON_ADDR_WIDTH-1:0] ADDR_ONE = FC_INNEURON_ADDR_WIDTH'(1);

  logic [1:0]                        state_q, state_d;
  logic [FC_COUNT_IN_BITWIDTH-1:0]   cnt_q, cnt_d;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH_FC-1:0]          hold_q, hold_d;
  logic                              wren_q, wren_d;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH_FC-1:0]          data_a_q, data_a_d;
  logic [DATA_WIDTH_FC-1:0]          data_b_q, data_b_d;
  logic                              load_done_q, load_done_d;
  logic                              fc_enable_q, fc_enable_d;
  logic                              accept;

  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    wren_d      = 1'b0;
    waddr_d     = waddr_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    load_done_d = 1'b0;
    fc_enable_d = fc_enable_q;

    case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        addr_d      = '0;
        fc_enable_d = 1'b0;
        if (start) state_d = S_LOAD;
      end

      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          if (!cnt_q[0]) begin
            hold_d = in_data;
          end else begin
            wren_d   = 1'b1;
            waddr_d  = addr_q;
            data_a_d = hold_q;
            data_b_d = in_data;
            // Address stays on the final pair so it never passes the last row.
            if (cnt_q != LAST_CNT) addr_d = addr_q + ADDR_ONE;
          end
          if (cnt_q == LAST_CNT) begin
            if (cnt_q[0]) begin
              load_done_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
      end

      S_FLUSH: begin
        // Odd neuron count: emit the held even word with a zero partner.
        wren_d      = 1'b1;
        waddr_d     = addr_q;
        data_a_d    = hold_q;
        data_b_d    = '0;
        load_done_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        // Enters DONE together with the last write, so enable rises one cycle later.
        fc_enable_d = 1'b1;
        if (start) begin
          fc_enable_d = 1'b0;
          cnt_d       = '0;
          addr_d      = '0;
          state_d     = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      wren_q      <= 1'b0;
      waddr_q     <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      load_done_q <= 1'b0;
      fc_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      wren_q      <= wren_d;
      waddr_q     <= waddr_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      load_done_q <= load_done_d;
      fc_enable_q <= fc_enable_d;
    end
  end

  assign in_neuron_wren_a    = wren_q;
  assign in_neuron_wren_b    = wren_q;
  assign in_neuron_address_a = waddr_q;
  assign in_neuron_address_b = waddr_q;
  assign in_neuron_data_a    = data_a_q;
  assign in_neuron_data_b    = data_b_q;
  assign busy                = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign load_done           = load_done_q;
  assign fc_enable           = fc_enable_q;

endmodule

// File: tb/tb_fc_inneuron_loader.sv
// Directed bench for fc_inneuron_loader: instance 0 with 6 neurons,
// instance 1 with 5 neurons (flush path). Writes are logged at the falling
// edge and compared against hand-computed RAM images.
module tb_fc_inneuron_loader;

  logic        clock;
  logic        reset;
  logic        start     [2];
  logic        in_valid  [2];
  logic [15:0] in_data   [2];
  logic        in_ready  [2];
  logic        wren_a    [2];
  logic        wren_b    [2];
  logic [7:0]  addr_a    [2];
  logic [7:0]  addr_b    [2];
  logic [15:0] data_a    [2];
  logic [15:0] data_b    [2];
  logic        busy      [2];
  logic        load_done [2];
  logic        fc_enable [2];

  fc_inneuron_loader #(.INNEURON(6), .DATA_WIDTH_FC(16), .FC_INNEURON_ADDR_WIDTH(8),
                       .FC_COUNT_IN_BITWIDTH(9)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]),
    .in_neuron_wren_a(wren_a[0]), .in_neuron_wren_b(wren_b[0]),
    .in_neuron_address_a(addr_a[0]), .in_neuron_address_b(addr_b[0]),
    .in_neuron_data_a(data_a[0]), .in_neuron_data_b(data_b[0]),
    .busy(busy[0]), .load_done(load_done[0]), .fc_enable(fc_enable[0]));

  fc_inneuron_loader #(.INNEURON(5), .DATA_WIDTH_FC(16), .FC_INNEURON_ADDR_WIDTH(8),
                       .FC_COUNT_IN_BITWIDTH(9)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]),
    .in_neuron_wren_a(wren_a[1]), .in_neuron_wren_b(wren_b[1]),
    .in_neuron_address_a(addr_a[1]), .in_neuron_address_b(addr_b[1]),
    .in_neuron_data_a(data_a[1]), .in_neuron_data_b(data_b[1]),
    .busy(busy[1]), .load_done(load_done[1]), .fc_enable(fc_enable[1]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Write log
  logic [7:0]  wr_addr [2][32];
  logic [15:0] wr_a    [2][32];
  logic [15:0] wr_b    [2][32];
  logic        wr_ld   [2][32];
  int          wr_cyc  [2][32];
  int          wr_n        [2] = '{0, 0};
  int          fc_rise_n   [2] = '{0, 0};
  int          fc_rise_cyc [2] = '{0, 0};
  logic        fc_prev     [2] = '{1'b0, 1'b0};
  int          pair_err = 0;
  int          ld_alone = 0;

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (wren_a[s]) begin
        if (wr_n[s] < 32) begin
          wr_addr[s][wr_n[s]] = addr_a[s];
          wr_a[s][wr_n[s]]    = data_a[s];
          wr_b[s][wr_n[s]]    = data_b[s];
          wr_ld[s][wr_n[s]]   = load_done[s];
          wr_cyc[s][wr_n[s]]  = cyc;
        end
        wr_n[s]++;
      end
      if (wren_a[s] !== wren_b[s] || addr_a[s] !== addr_b[s]) pair_err++;
      if (load_done[s] && !wren_a[s]) ld_alone++;
      if (fc_enable[s] && !fc_prev[s]) begin
        fc_rise_n[s]++;
        fc_rise_cyc[s] = cyc;
      end
      fc_prev[s] = fc_enable[s];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_wr(input int s, input int idx, input int addr, input int a,
                          input int b, input int ld);
    check($sformatf("wr_addr[%0d][%0d]", s, idx), 32'(wr_addr[s][idx]), addr);
    check($sformatf("wr_a[%0d][%0d]", s, idx), 32'(wr_a[s][idx]), a);
    check($sformatf("wr_b[%0d][%0d]", s, idx), 32'(wr_b[s][idx]), b);
    check($sformatf("wr_ld[%0d][%0d]", s, idx), 32'(wr_ld[s][idx]), ld);
  endtask

  task automatic pulse_start(input int s);
    start[s] = 1'b1;
    @(posedge clock); #1;
    start[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [15:0] v);
    logic rdy;
    in_valid[s] = 1'b1;
    in_data[s]  = v;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready[s];
      @(posedge clock); #1;
      if (rdy) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int s, input int n);
    in_valid[s] = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input int s, input string tag);
    check({tag, "_wren_a"}, 32'(wren_a[s]), 0);
    check({tag, "_wren_b"}, 32'(wren_b[s]), 0);
    check({tag, "_addr_a"}, 32'(addr_a[s]), 0);
    check({tag, "_addr_b"}, 32'(addr_b[s]), 0);
    check({tag, "_data_a"}, 32'(data_a[s]), 0);
    check({tag, "_data_b"}, 32'(data_b[s]), 0);
    check({tag, "_busy"}, 32'(busy[s]), 0);
    check({tag, "_load_done"}, 32'(load_done[s]), 0);
    check({tag, "_fc_enable"}, 32'(fc_enable[s]), 0);
    check({tag, "_in_ready"}, 32'(in_ready[s]), 0);
  endtask

  int b, r;

  initial begin
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s]    = 1'b0;
      in_valid[s] = 1'b0;
      in_data[s]  = '0;
    end
    repeat (2) @(posedge clock); #1;
    check_outputs_zero(0, "rst0");
    check_outputs_zero(1, "rst1");
    reset = 1'b1;
    @(posedge clock); #1;

    // Six neurons back-to-back
    b = wr_n[0]; r = fc_rise_n[0];
    pulse_start(0);
    check("t1_busy", 32'(busy[0]), 1);
    check("t1_in_ready", 32'(in_ready[0]), 1);
    for (int v = 1; v <= 6; v++) send(0, 16'(v));
    idle(0, 4);
    check("t1_nwr", wr_n[0] - b, 3);
    for (int k = 0; k < 3; k++) check_wr(0, b + k, k, 2 * k + 1, 2 * k + 2, (k == 2) ? 1 : 0);
    check("t1_fc_rises", fc_rise_n[0] - r, 1);
    check("t1_fc_lat", fc_rise_cyc[0] - wr_cyc[0][b + 2], 1);
    check("t1_fc_hold", 32'(fc_enable[0]), 1);
    check("t1_busy_done", 32'(busy[0]), 0);

    // Five neurons: flush pads with zero
    b = wr_n[1]; r = fc_rise_n[1];
    pulse_start(1);
    for (int v = 10; v <= 14; v++) send(1, 16'(v));
    check("t2_ready_flush", 32'(in_ready[1]), 0);
    check("t2_busy_flush", 32'(busy[1]), 1);
    idle(1, 4);
    check("t2_nwr", wr_n[1] - b, 3);
    check_wr(1, b + 0, 0, 10, 11, 0);
    check_wr(1, b + 1, 1, 12, 13, 0);
    check_wr(1, b + 2, 2, 14, 0, 1);
    check("t2_fc_rises", fc_rise_n[1] - r, 1);
    check("t2_fc_lat", fc_rise_cyc[1] - wr_cyc[1][b + 2], 1);
    check("t2_fc_hold", 32'(fc_enable[1]), 1);

    // Second inference from DONE
    b = wr_n[0]; r = fc_rise_n[0];
    pulse_start(0);
    check("t5_fc_drop", 32'(fc_enable[0]), 0);
    check("t5_busy", 32'(busy[0]), 1);
    for (int v = 7; v <= 12; v++) send(0, 16'(v));
    idle(0, 4);
    check("t5_nwr", wr_n[0] - b, 3);
    for (int k = 0; k < 3; k++) check_wr(0, b + k, k, 2 * k + 7, 2 * k + 8, (k == 2) ? 1 : 0);
    check("t5_fc_rises", fc_rise_n[0] - r, 1);
    check("t5_fc_lat", fc_rise_cyc[0] - wr_cyc[0][b + 2], 1);

    // Bubbles between every neuron
    b = wr_n[0];
    pulse_start(0);
    for (int v = 1; v <= 6; v++) begin
      send(0, 16'(v));
      idle(0, 1);
    end
    idle(0, 4);
    check("t3_nwr", wr_n[0] - b, 3);
    for (int k = 0; k < 3; k++) check_wr(0, b + k, k, 2 * k + 1, 2 * k + 2, (k == 2) ? 1 : 0);
    check("t3_spacing01", wr_cyc[0][b + 1] - wr_cyc[0][b], 4);
    check("t3_spacing12", wr_cyc[0][b + 2] - wr_cyc[0][b + 1], 4);

    // Asynchronous reset mid-load
    pulse_start(0);
    send(0, 16'd31); send(0, 16'd32); send(0, 16'd33);
    in_valid[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_outputs_zero(0, "t4_rst0");
    check("t4_rst1_fc", 32'(fc_enable[1]), 0);
    b = wr_n[0];
    repeat (3) @(posedge clock); #1;
    reset = 1'b1;
    idle(0, 2);
    check("t4_no_pending", wr_n[0] - b, 0);
    b = wr_n[0];
    pulse_start(0);
    for (int v = 21; v <= 26; v++) send(0, 16'(v));
    idle(0, 4);
    check("t4_nwr", wr_n[0] - b, 3);
    for (int k = 0; k < 3; k++) check_wr(0, b + k, k, 2 * k + 21, 2 * k + 22, (k == 2) ? 1 : 0);

    // in_valid in IDLE and start during LOAD are ignored
    b = wr_n[1];
    in_valid[1] = 1'b1;
    in_data[1]  = 16'd99;
    repeat (3) @(posedge clock); #1;
    check("t6_ready_idle", 32'(in_ready[1]), 0);
    check("t6_nwr_idle", wr_n[1] - b, 0);
    pulse_start(1);
    for (int v = 10; v <= 12; v++) send(1, 16'(v));
    in_valid[1] = 1'b0;
    pulse_start(1);
    send(1, 16'd13); send(1, 16'd14);
    idle(1, 4);
    check("t6_nwr", wr_n[1] - b, 3);
    check_wr(1, b + 0, 0, 10, 11, 0);
    check_wr(1, b + 1, 1, 12, 13, 0);
    check_wr(1, b + 2, 2, 14, 0, 1);

    check("pair_consistency", pair_err, 0);
    check("load_done_alone", ld_alone, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
